// File: rtl/codec_cfg_seq_if.sv
// Byte handshake between the codec configuration sequencer and the serial transmitter.
// The sequencer is the master: it offers bytes and the transmitter reports completion.
interface codec_cfg_seq_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       tx_first;
  logic       tx_last;
  logic       tx_done;
  logic       tx_nack;

  modport master (
    output tx_valid, tx_byte, tx_first, tx_last,
    input  tx_ready, tx_done, tx_nack
  );

  modport slave (
    input  tx_valid, tx_byte, tx_first, tx_last,
    output tx_ready, tx_done, tx_nack
  );
endinterface

// File: rtl/codec_cfg_seq.sv
// Walks a ROM table of 16-bit register words and sends each as DEV_ADDR, high byte, low byte,
// with an idle gap between transactions and a bounded retry on NACK.
module codec_cfg_seq #(
  parameter int         NUM_REGS   = 7,
  parameter logic [7:0] DEV_ADDR   = 8'h34,
  parameter int         GAP_CYCLES = 4,
  parameter int         MAX_RETRY  = 2,
  localparam int        IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [15:0]      tbl_word,
  codec_cfg_seq_if.master  tx,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx
);

  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ADDR, HI, LO, GAP} state_t;

  state_t           state, state_nxt;
  logic             wait_done, wait_nxt;
  logic             retry_pend, pend_nxt;
  logic [RTY_W-1:0] retry_cnt, retry_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [IDX_W-1:0] idx_nxt, err_idx_nxt;
  logic             busy_nxt, done_nxt, error_nxt;
  logic             valid_q, valid_nxt;
  logic [7:0]       byte_q, byte_nxt;
  logic             first_q, first_nxt;
  logic             last_q, last_nxt;

  logic accept, byte_done, gap_end, give_up;

  // wait_done marks an accepted byte whose tx_done has not arrived yet
  assign accept    = valid_q & tx.tx_ready;
  assign byte_done = wait_done & tx.tx_done;
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
  assign give_up   = retry_pend && (retry_cnt == RETRY_LIM);

  assign tx.tx_valid = valid_q;
  assign tx.tx_byte  = byte_q;
  assign tx.tx_first = first_q;
  assign tx.tx_last  = last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_done  <= 1'b0;
      retry_pend <= 1'b0;
      retry_cnt  <= '0;
      gap_cnt    <= '0;
      tbl_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_idx    <= '0;
      valid_q    <= 1'b0;
      byte_q     <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_done  <= wait_nxt;
      retry_pend <= pend_nxt;
      retry_cnt  <= retry_nxt;
      gap_cnt    <= gap_nxt;
      tbl_idx    <= idx_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      err_idx    <= err_idx_nxt;
      valid_q    <= valid_nxt;
      byte_q     <= byte_nxt;
      first_q    <= first_nxt;
      last_q     <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADDR;
      ADDR:    if (byte_done) state_nxt = tx.tx_nack ? GAP : HI;
      HI:      if (byte_done) state_nxt = tx.tx_nack ? GAP : LO;
      LO:      if (byte_done) state_nxt = (tx.tx_nack || tbl_idx != LAST_IDX) ? GAP : IDLE;
      GAP:     if (gap_end) state_nxt = give_up ? IDLE : ADDR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wait_nxt    = wait_done;
    pend_nxt    = retry_pend;
    retry_nxt   = retry_cnt;
    gap_nxt     = gap_cnt;
    idx_nxt     = tbl_idx;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    error_nxt   = error;
    err_idx_nxt = err_idx;
    valid_nxt   = valid_q;
    byte_nxt    = byte_q;
    first_nxt   = first_q;
    last_nxt    = last_q;

    if (accept) begin
      valid_nxt = 1'b0;
      wait_nxt  = 1'b1;
    end
    if (byte_done) wait_nxt = 1'b0;

    case (state)
      IDLE: if (start) begin
        error_nxt   = 1'b0;
        err_idx_nxt = '0;
        retry_nxt   = '0;
        pend_nxt    = 1'b0;
        idx_nxt     = '0;
        busy_nxt    = 1'b1;
      end
      ADDR, HI, LO: if (byte_done) begin
        gap_nxt = '0;
        if (tx.tx_nack) begin
          pend_nxt = 1'b1;
        end else if (state == LO) begin
          pend_nxt  = 1'b0;
          retry_nxt = '0;
          if (tbl_idx == LAST_IDX) begin
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
            idx_nxt  = '0;
          end
        end
      end
      GAP: if (gap_end) begin
        // the retry budget is checked only when the retry would actually start
        if (give_up) begin
          error_nxt   = 1'b1;
          err_idx_nxt = tbl_idx;
          busy_nxt    = 1'b0;
          idx_nxt     = '0;
          pend_nxt    = 1'b0;
        end else if (retry_pend) begin
          retry_nxt = retry_cnt + RTY_W'(1);
          pend_nxt  = 1'b0;
        end else begin
          idx_nxt = tbl_idx + IDX_W'(1);
        end
      end else begin
        gap_nxt = gap_cnt + GAP_W'(1);
      end
      default: ;
    endcase

    // a byte is loaded once on entry to its state; tbl_idx is already stable then
    if (state_nxt != state) begin
      case (state_nxt)
        ADDR: begin
          valid_nxt = 1'b1;
          byte_nxt  = DEV_ADDR;
          first_nxt = 1'b1;
          last_nxt  = 1'b0;
        end
        HI: begin
          valid_nxt = 1'b1;
          byte_nxt  = tbl_word[15:8];
          first_nxt = 1'b0;
          last_nxt  = 1'b0;
        end
        LO: begin
          valid_nxt = 1'b1;
          byte_nxt  = tbl_word[7:0];
          first_nxt = 1'b0;
          last_nxt  = 1'b1;
        end
        default: begin
          valid_nxt = 1'b0;
          byte_nxt  = '0;
          first_nxt = 1'b0;
          last_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/codec_cfg_seq.md
CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 7, number of register writes in the configuration table (>=1).
REQ-002 SHALL have parameter DEV_ADDR, default 8'h34, 8-bit device write address byte sent first in every transaction.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, idle clocks between transactions (>=1).
REQ-004 SHALL have parameter MAX_RETRY, default 2, retries per entry after NACK before failing; IDX_W = clog2(NUM_REGS), minimum 1.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have: start  in  1  one-cycle request to run the full table.
REQ-008 SHALL have: tbl_idx  out  IDX_W  current table index driven to external ROM.
REQ-009 SHALL have: tbl_word  in  16  ROM entry for tbl_idx, combinational, valid same cycle.
REQ-010 SHALL have: tx_valid  out  1; tx_ready  in  1; tx_byte  out  8 -- byte handshake to serial transmitter.
REQ-011 SHALL have: tx_first  out  1  START condition precedes this byte; tx_last  out  1  STOP follows this byte.
REQ-012 SHALL have: tx_done  in  1  one-cycle pulse when accepted byte finished; tx_nack  in  1  qualified by tx_done.
REQ-013 SHALL have: busy  out  1; done  out  1  one-cycle success pulse; error  out  1  sticky; err_idx  out  IDX_W  failing index.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, HI, LO, GAP, with all outputs registered.
REQ-015 SHALL, in IDLE on start=1, clear error, err_idx and retry count, set tbl_idx=0, set busy=1 and enter ADDR; tx_valid asserts the cycle after start.
REQ-016 SHALL, in ADDR, present tx_byte=DEV_ADDR, tx_first=1, tx_last=0.
REQ-017 SHALL, in HI, present tx_byte=tbl_word[15:8], tx_first=0, tx_last=0.
REQ-018 SHALL, in LO, present tx_byte=tbl_word[7:0], tx_first=0, tx_last=1.
REQ-019 SHALL hold tx_valid and tx_byte stable until a cycle with tx_valid=1 and tx_ready=1 (accept), then deassert tx_valid the next cycle and wait for tx_done.
REQ-020 SHALL ignore tx_done when no byte is outstanding.
REQ-021 SHALL, on tx_done with tx_nack=0, advance ADDR->HI->LO; after LO go to GAP.
REQ-022 SHALL, on tx_done with tx_nack=1 in any byte state, abandon the entry and go to GAP with retry pending; tbl_idx unchanged.
REQ-023 SHALL count GAP_CYCLES clocks in GAP, then enter ADDR for the same entry (retry) or the next entry (success).
REQ-024 SHALL, on a retry, increment retry count; if it would exceed MAX_RETRY, instead set error=1, err_idx=tbl_idx, busy=0, done stays 0, enter IDLE.
REQ-025 SHALL reset retry count to 0 whenever an entry completes without NACK.
REQ-026 SHALL, after successful LO of index NUM_REGS-1, skip GAP, pulse done for one cycle, clear busy, return tbl_idx to 0 and enter IDLE.
REQ-027 SHALL ignore start while busy=1; simultaneous start and completion in the same cycle SHALL not begin a new run.
REQ-028 SHALL only index ROM within 0..NUM_REGS-1; tbl_idx never wraps past NUM_REGS-1.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-byte, immediately enter IDLE with tbl_idx=0, tx_valid=0, tx_byte=0, tx_first=0, tx_last=0, busy=0, done=0, error=0, err_idx=0, retry=0, gap counter=0.
REQ-030 SHALL resume normal operation only via a new start after rst deasserts; no partial transaction resumes.

Verification
REQ-031 Defaults, ROM of 7 entries, tx_ready=1, tx_done 3 cycles after accept, no NACK -> 21 bytes 34,hi0,lo0,34,...; tx_first on every 34, tx_last on every lo; done pulses once; busy low after.
REQ-032 tx_ready held 0 for 5 cycles on HI of entry 2 -> tx_valid and tx_byte=tbl_word[15:8] held stable all 5 cycles; single byte accepted.
REQ-033 NACK on LO of entry 3 once -> after 4 gap cycles entry 3 resent from 34; run completes with done=1, error=0.
REQ-034 NACK on ADDR of entry 1 three times (MAX_RETRY=2) -> error=1, err_idx=1, busy=0, done never pulses; next start clears error.
REQ-035 rst pulsed while waiting tx_done on entry 4 -> all outputs zero immediately; later start runs from entry 0.
REQ-036 start pulsed while busy and coincident with final done -> ignored; exactly one run observed.
